// File: rtl/acum_writeback.sv
// acum_writeback: requantize final accumulator sums and stream them out through a small FIFO; optional ReLU under ACUM_WB_RELU_EN
module acum_writeback #(
    parameter int IN_W       = 32,
    parameter int OUT_W      = 8,
    parameter int ROWS       = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int SHIFT_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SHIFT_W-1:0] cfg_shift,
`ifdef ACUM_WB_RELU_EN
    input  logic               cfg_relu,
`endif
    input  logic               in_valid,
    input  logic [IN_W-1:0]    in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_last,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic [7:0]         sat_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic signed [IN_W:0] ONE   = 1;
    localparam logic signed [IN_W:0] MAX_V = (IN_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [IN_W:0] MIN_V = ~MAX_V;
    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;
    state_t             state_q, state_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [RW-1:0]      row_q, row_d;
    logic               s1_valid_q, s1_valid_d;
    logic [OUT_W-1:0]   s1_data_q, s1_data_d;
    logic               s1_last_q, s1_last_d;
    logic [OUT_W:0]     mem_q [FIFO_DEPTH];
    logic [OUT_W:0]     mem_d [FIFO_DEPTH];
    logic [AW-1:0]      wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic [7:0]         sat_q, sat_d;
`ifdef ACUM_WB_RELU_EN
    logic               relu_q, relu_d;
`endif
    logic signed [IN_W:0] s_ext, rnd, r, rl;
    logic                 big, sat_hi, sat_lo, accept, pop, row_last;
    logic [OUT_W-1:0]     q;
    logic [OUT_W:0]       head;
    assign in_ready  = (state_q == ACTIVE) && ((cnt_q + CW'(s1_valid_q)) < CW'(FIFO_DEPTH));
    assign accept    = in_valid & in_ready;
    assign out_valid = cnt_q != '0;
    assign pop       = out_valid & out_ready;
    assign head      = mem_q[rp_q];
    assign out_data  = out_valid ? head[OUT_W-1:0] : '0;
    assign out_last  = out_valid & head[OUT_W];
    assign busy      = state_q != IDLE;
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign sat_cnt   = sat_q;
    assign row_last  = row_q == RW'(ROWS - 1);
    // Round-half-up arithmetic shift, optional ReLU, then signed clamp to OUT_W
    always_comb begin
        s_ext  = {in_data[IN_W-1], in_data};
        rnd    = (shift_q == '0) ? '0 : ONE << (shift_q - 1'b1);
        big    = 32'(shift_q) >= IN_W;
        r      = big ? $signed({(IN_W+1){in_data[IN_W-1]}}) : (s_ext + rnd) >>> shift_q;
`ifdef ACUM_WB_RELU_EN
        rl     = (relu_q && r[IN_W]) ? '0 : r;
`else
        rl     = r;
`endif
        sat_hi = rl > MAX_V;
        sat_lo = rl < MIN_V;
        q      = sat_hi ? MAX_V[OUT_W-1:0] : sat_lo ? MIN_V[OUT_W-1:0] : rl[OUT_W-1:0];
    end
    // Next-state for the tile FSM, stage-1 register and the first-word-fall-through FIFO
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        row_d      = row_q;
        ovf_d      = ovf_q;
        sat_d      = sat_q;
        done_d     = 1'b0;
`ifdef ACUM_WB_RELU_EN
        relu_d     = relu_q;
`endif
        s1_valid_d = accept;
        s1_data_d  = q;
        s1_last_d  = row_last;
        mem_d      = mem_q;
        wp_d       = wp_q;
        rp_d       = pop ? rp_q + 1'b1 : rp_q;
        cnt_d      = cnt_q + CW'(s1_valid_q) - CW'(pop);
        if (s1_valid_q) begin
            mem_d[wp_q] = {s1_last_q, s1_data_q};
            wp_d        = wp_q + 1'b1;
        end
        case (state_q)
            IDLE: if (start) begin
                state_d = ACTIVE;
                shift_d = cfg_shift;
                row_d   = '0;
                sat_d   = '0;
                ovf_d   = 1'b0;
`ifdef ACUM_WB_RELU_EN
                relu_d  = cfg_relu;
`endif
            end
            ACTIVE: begin
                if (in_valid && !in_ready) ovf_d = 1'b1;
                if (accept) begin
                    row_d   = row_last ? '0 : row_q + 1'b1;
                    sat_d   = ((sat_hi || sat_lo) && sat_q != 8'hFF) ? sat_q + 8'd1 : sat_q;
                    state_d = row_last ? FLUSH : ACTIVE;
                end
            end
            FLUSH: if (!s1_valid_q && cnt_q == '0) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    // Single register bank; reset discards any in-flight tile
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            row_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_last_q  <= 1'b0;
            mem_q      <= '{default: '0};
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            sat_q      <= '0;
`ifdef ACUM_WB_RELU_EN
            relu_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            row_q      <= row_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_last_q  <= s1_last_d;
            mem_q      <= mem_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            sat_q      <= sat_d;
`ifdef ACUM_WB_RELU_EN
            relu_q     <= relu_d;
`endif
        end
    end
endmodule

// File: tb/tb_acum_writeback.sv
// tb_acum_writeback: directed scoreboard bench for acum_writeback
module tb_acum_writeback;
    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_ready, out_valid, out_last, out_ready, busy, done, overflow;
    logic [4:0]  cfg_shift;
    logic [31:0] in_data;
    logic [7:0]  out_data, sat_cnt;
`ifdef ACUM_WB_RELU_EN
    logic        cfg_relu = 1'b0;
`endif
    typedef struct packed {logic [7:0] d; logic l;} exp_t;
    exp_t sb[$];
    int   checks = 0, failures = 0;
    int   m_shift = 0, m_row = 0, m_sat = 0;
    bit   m_relu = 1'b0;

    acum_writeback dut (
        .clk(clk), .rst(rst), .start(start), .cfg_shift(cfg_shift),
`ifdef ACUM_WB_RELU_EN
        .cfg_relu(cfg_relu),
`endif
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .done(done), .overflow(overflow), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rq(input longint x, output bit sat);
        longint v, d, q;
        v = x;
        if (m_shift > 0) v += longint'(1) << (m_shift - 1);
        d = longint'(1) << m_shift;
        q = v / d;
        if (v < 0 && (v % d) != 0) q--;
        if (m_relu && q < 0) q = 0;
        sat = (q > 127) || (q < -128);
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q[7:0];
    endfunction

    task automatic tick();
        exp_t e;
        bit   s;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) check("sb_size_on_pop", 32'(sb.size()), 1);
            else begin
                e = sb.pop_front();
                check("out_data", 32'(out_data), 32'(e.d));
                check("out_last", 32'(out_last), 32'(e.l));
            end
        end
        if (in_valid && in_ready) begin
            e.d   = rq(longint'($signed(in_data)), s);
            e.l   = (m_row == 15);
            m_row = e.l ? 0 : m_row + 1;
            if (s) m_sat++;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_tile(input int sh, input bit relu);
        cfg_shift = 5'(sh);
        start     = 1'b1;
        m_shift   = sh;
        m_relu    = relu;
        m_row     = 0;
        m_sat     = 0;
`ifdef ACUM_WB_RELU_EN
        cfg_relu  = relu;
`endif
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        check("ovf_cleared", 32'(overflow), 0);
        check("sat_cleared", 32'(sat_cnt), 0);
    endtask

    task automatic send(input int v);
        int t = 0;
        in_valid = 1'b0;
        while (!in_ready && t < 100) begin
            tick();
            t++;
        end
        check("send_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        out_ready = 1'b1;
        while (!done && t < 200) begin
            tick();
            t++;
        end
        check("done_seen", 32'(done), 1);
        check("sb_empty_at_done", 32'(sb.size()), 0);
        check("busy_at_done", 32'(busy), 0);
        tick();
        check("done_pulse", 32'(done), 0);
    endtask

    initial begin
        int vals[8] = '{24, 23, -24, 1000, 5000, -5000, -8, -9};
        rst = 1'b1; start = 1'b0; cfg_shift = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_sat_cnt", 32'(sat_cnt), 0);
        rst = 1'b0;
        tick();
        // tile 1: identity, two-cycle latency then streaming
        start_tile(0, 1'b0);
        send(0);
        check("lat_stage1", 32'(out_valid), 0);
        tick();
        check("lat_stage2", 32'(out_valid), 1);
        out_ready = 1'b1;
        for (int i = 1; i < 16; i++) send(i);
        wait_done();
        check("tile1_sat", 32'(sat_cnt), 0);
        // tile 2: shift 4 rounding and saturation; a start mid-tile is ignored
        start_tile(4, 1'b0);
        for (int i = 0; i < 4; i++) send(vals[i]);
        cfg_shift = 5'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 4; i < 8; i++) send(vals[i]);
        for (int i = 8; i < 16; i++) send(i * 3);
        wait_done();
        check("tile2_sat", 32'(sat_cnt), 2);
        // tile 3: backpressure fills FIFO, then an offered beat is dropped
        out_ready = 1'b0;
        start_tile(0, 1'b0);
        for (int i = 0; i < 4; i++) send(100 + i);
        check("in_ready_full", 32'(in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_valid", 32'(out_valid), 1);
            check("hold_data", 32'(out_data), 100);
        end
        check("no_ovf_bp", 32'(overflow), 0);
        in_valid = 1'b1;
        in_data  = 555;
        tick();
        in_valid = 1'b0;
        check("ovf_set", 32'(overflow), 1);
        out_ready = 1'b1;
        for (int i = 4; i < 16; i++) send(100 + i);
        wait_done();
        check("ovf_sticky", 32'(overflow), 1);
        // tile 4: reset after 7 beats discards everything
        start_tile(0, 1'b0);
        for (int i = 0; i < 7; i++) send(200 + i);
        rst = 1'b1;
        tick();
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_in_ready", 32'(in_ready), 0);
        rst = 1'b0;
        sb.delete();
        m_row = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrst_no_done", 32'(done), 0);
            check("midrst_idle_valid", 32'(out_valid), 0);
        end
        // tile 5: fresh tile after reset
        start_tile(2, 1'b0);
        for (int i = 0; i < 16; i++) send(i * 37 - 300);
        wait_done();
`ifdef ACUM_WB_RELU_EN
        // tile 6: ReLU zeroes negatives without counting them as saturation
        start_tile(0, 1'b1);
        send(-3);
        send(200);
        for (int i = 2; i < 16; i++) send(0);
        wait_done();
        check("relu_sat", 32'(sat_cnt), 1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
